// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Multi-cycle data-memory responder for the Core load/store port.
//            A MemRead/MemWrite request seen in IDLE is latched, held for
//            LATENCY clock edges, then completed with a one-cycle Ready pulse
//            carrying read data or an Error flag.
// Ports    : Clk        - clock, all state changes on the rising edge
//            Reset      - synchronous, active-high reset
//            Address    - byte address, word index = Address[DEPTH_LOG2+1:2]
//            WriteData  - store data
//            MemRead    - load request
//            MemWrite   - store request
//            ReadData   - load result, valid while Ready=1 and Error=0
//            Ready      - one-cycle completion pulse
//            Error      - qualifies Ready, request was rejected
//            Busy       - high whenever the responder is not idle
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Error,
    output logic        Busy
);

    localparam int         c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [3:0]              r_count;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic                    r_read;
    logic                    r_write;
    logic [31:0]             r_readData;
    logic                    r_ready;
    logic                    r_error;
    logic [31:0]             r_mem [c_DEPTH] = '{default: '0};

    logic                    w_accept;
    logic                    w_enterDone;
    logic                    w_err;
    logic [DEPTH_LOG2-1:0]   w_index;

    // Every request passes through WAIT, even at LATENCY=1 (counter loaded
    // with 0, so WAIT lasts exactly one cycle). This keeps Ready a fixed
    // LATENCY edges after acceptance and means completion always works from
    // the latched copy of the request, never from the live inputs.
    assign w_accept    = (r_state == ST_IDLE) && (MemRead || MemWrite);
    assign w_enterDone = (r_state == ST_WAIT) && (r_count == 4'd0);

    // Rejection classes, evaluated on the latched request.
    assign w_err   = (r_read && r_write)
                   || (r_addr[1:0] != 2'b00)
                   || (r_addr[31:DEPTH_LOG2+2] != '0);
    assign w_index = r_addr[DEPTH_LOG2+1:2];

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_nextState = ST_WAIT;
            ST_WAIT: if (w_enterDone) w_nextState = ST_DONE;
            ST_DONE:                  w_nextState = ST_IDLE;
            default:                  w_nextState = ST_IDLE;
        endcase
    end

    // Request latch, countdown and completion outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count    <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_readData <= 32'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= Address;
                r_wdata <= WriteData;
                r_read  <= MemRead;
                r_write <= MemWrite;
                r_count <= c_COUNT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end

            // DONE lasts a single cycle, so the completion outputs simply
            // return to zero on every edge that does not enter DONE.
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_readData <= 32'd0;
            if (w_enterDone) begin
                r_ready <= 1'b1;
                r_error <= w_err;
                if (!w_err && !r_write) begin
                    r_readData <= r_mem[w_index];
                end
            end
        end
    end

    // Storage is never cleared by reset; a reset during WAIT drops the
    // pending write because the commit is gated by the same edge.
    always_ff @(posedge Clk) begin
        if (!Reset && w_enterDone && !w_err && r_write) begin
            r_mem[w_index] <= r_wdata;
        end
    end

    assign ReadData = r_readData;
    assign Ready    = r_ready;
    assign Error    = r_error;
    assign Busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder. A word-array model
//            of the storage plus the rejection rules supplies every expected
//            value; directed scenarios are followed by a randomized run and a
//            full read-back sweep of the storage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    parameter int DEPTH_LOG2 = 8;
    parameter int LATENCY    = 2;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Error;
    logic        Busy;

    data_mem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LATENCY    (LATENCY)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .Error     (Error),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference storage
    logic [31:0] model [DEPTH];

    // Observations of the last transaction
    int          obsLat;
    logic [31:0] obsData;
    logic        obsErr;
    logic        obsBusyReady;
    logic        obsBusyAfter;
    logic        obsReadyAfter;

    function automatic bit modelErr(input bit rd, input bit wr, input logic [31:0] a);
        return (rd && wr) || ((a % 4) != 0) || (longint'(a) >= longint'(4 * DEPTH));
    endfunction

    // Applies a request to the model and returns the ReadData it must produce.
    function automatic logic [31:0] modelApply(input bit rd, input bit wr,
                                               input logic [31:0] a, input logic [31:0] wd);
        if (modelErr(rd, wr, a)) return 32'd0;
        if (wr) begin
            model[a / 4] = wd;
            return 32'd0;
        end
        return model[a / 4];
    endfunction

    // Issues one request in IDLE, drops it after acceptance, and records when
    // Ready arrives (cycles counted from the cycle right after acceptance).
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input bit scramble);
        @(negedge Clk);
        MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd;
        @(posedge Clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        obsLat = -1; obsData = 'x; obsErr = 'x;
        obsBusyReady = 1'b0; obsBusyAfter = 1'b1; obsReadyAfter = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (obsLat < 0 && Ready === 1'b1) begin
                obsLat = c; obsData = ReadData; obsErr = Error; obsBusyReady = Busy;
            end else if (obsLat >= 0) begin
                obsBusyAfter = Busy; obsReadyAfter = Ready;
                break;
            end
            if (scramble) begin
                Address = $urandom; WriteData = $urandom;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", Ready); end
        checks++; if (Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", Error); end
        checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", ReadData); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        Reset = 1'b0;
    endtask

    task automatic test_write_read;
        logic [31:0] exp;
        exp = modelApply(0, 1, 32'h10, 32'hDEADBEEF);
        do_req(0, 1, 32'h10, 32'hDEADBEEF, 0);
        checks++; if (obsLat != LATENCY) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", obsLat, LATENCY); end
        checks++; if (obsErr !== 1'b0) begin errors++; $display("FAIL wr_error: got %b expected 0", obsErr); end
        checks++; if (obsData !== exp) begin errors++; $display("FAIL wr_rdata: got %h expected %h", obsData, exp); end
        checks++; if (obsBusyReady !== 1'b1) begin errors++; $display("FAIL wr_busy_done: got %b expected 1", obsBusyReady); end
        checks++; if (obsBusyAfter !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b expected 0", obsBusyAfter); end
        checks++; if (obsReadyAfter !== 1'b0) begin errors++; $display("FAIL wr_ready_width: got %b expected 0", obsReadyAfter); end

        exp = modelApply(1, 0, 32'h10, 32'h0);
        do_req(1, 0, 32'h10, 32'h0, 0);
        checks++; if (obsLat != LATENCY) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", obsLat, LATENCY); end
        checks++; if (obsData !== 32'hDEADBEEF || obsData !== exp) begin errors++; $display("FAIL rd_data: got %h expected %h", obsData, exp); end
        checks++; if (obsErr !== 1'b0) begin errors++; $display("FAIL rd_error: got %b expected 0", obsErr); end

        exp = modelApply(1, 0, 32'h3FC, 32'h0);
        do_req(1, 0, 32'h3FC, 32'h0, 0);
        checks++; if (obsData !== exp) begin errors++; $display("FAIL rd_unwritten: got %h expected %h", obsData, exp); end
        checks++; if (obsErr !== 1'b0) begin errors++; $display("FAIL rd_unwritten_err: got %b expected 0", obsErr); end
    endtask

    task automatic test_errors;
        bit          rdTab [3] = '{1'b1, 1'b1, 1'b1};
        bit          wrTab [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] adTab [3] = '{32'h12, 32'h10, 32'h400};
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            exp = modelApply(rdTab[i], wrTab[i], adTab[i], 32'h5555_5555);
            do_req(rdTab[i], wrTab[i], adTab[i], 32'h5555_5555, 0);
            checks++; if (obsLat != LATENCY) begin errors++; $display("FAIL err%0d_latency: got %0d expected %0d", i, obsLat, LATENCY); end
            checks++; if (obsErr !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b expected 1", i, obsErr); end
            checks++; if (obsData !== exp) begin errors++; $display("FAIL err%0d_rdata: got %h expected %h", i, obsData, exp); end
        end
        exp = modelApply(1, 0, 32'h10, 32'h0);
        do_req(1, 0, 32'h10, 32'h0, 0);
        checks++; if (obsData !== exp) begin errors++; $display("FAIL err_storage_kept: got %h expected %h", obsData, exp); end
    endtask

    task automatic test_wait_ignores_inputs;
        logic [31:0] exp;
        exp = modelApply(0, 1, 32'h20, 32'h1234);
        do_req(0, 1, 32'h20, 32'h1234, 1);
        checks++; if (obsLat != LATENCY) begin errors++; $display("FAIL scramble_latency: got %0d expected %0d", obsLat, LATENCY); end
        checks++; if (obsErr !== 1'b0) begin errors++; $display("FAIL scramble_error: got %b expected 0", obsErr); end
        exp = modelApply(1, 0, 32'h20, 32'h0);
        do_req(1, 0, 32'h20, 32'h0, 0);
        checks++; if (obsData !== exp) begin errors++; $display("FAIL scramble_data: got %h expected %h", obsData, exp); end
    endtask

    task automatic test_reset_in_wait;
        int          pulses;
        logic [31:0] exp;
        @(negedge Clk);
        MemWrite = 1'b1; Address = 32'h30; WriteData = 32'hCAFE;
        @(posedge Clk);
        #1;
        MemWrite = 1'b0; Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", Busy); end
        pulses = (Ready === 1'b1) ? 1 : 0;
        for (int c = 0; c < LATENCY + 3; c++) begin
            @(negedge Clk);
            if (Ready === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_ready: got %0d pulses expected 0", pulses); end
        exp = modelApply(1, 0, 32'h30, 32'h0);
        do_req(1, 0, 32'h30, 32'h0, 0);
        checks++; if (obsData !== exp) begin errors++; $display("FAIL abort_discard: got %h expected %h", obsData, exp); end
    endtask

    task automatic test_reset_with_request;
        int pulses;
        @(negedge Clk);
        Reset = 1'b1; MemRead = 1'b1; Address = 32'h10;
        @(posedge Clk);
        #1;
        Reset = 1'b0; MemRead = 1'b0;
        pulses = 0;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstreq_busy: got %b expected 0", Busy); end
        for (int c = 0; c < LATENCY + 3; c++) begin
            @(negedge Clk);
            if (Ready === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstreq_ready: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_random;
        bit          rd, wr;
        int          sel;
        logic [31:0] addr, wd, exp;
        bit          expE;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel <= 4) || (sel == 9);
            wr  = (sel >= 5);
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 1) addr = 32'(4 * DEPTH) + ($urandom & 32'h00FF_FFFC);
            else               addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            wd   = $urandom;
            expE = modelErr(rd, wr, addr);
            exp  = modelApply(rd, wr, addr, wd);
            do_req(rd, wr, addr, wd, 0);
            checks++; if (obsLat != LATENCY) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, obsLat, LATENCY); end
            checks++; if (obsErr !== expE) begin errors++; $display("FAIL rand%0d_error: addr %h got %b expected %b", n, addr, obsErr, expE); end
            checks++; if (obsData !== exp) begin errors++; $display("FAIL rand%0d_data: addr %h got %h expected %h", n, addr, obsData, exp); end
        end
    endtask

    task automatic test_back_to_back;
        int          when [$];
        logic [31:0] exp;
        int          idleSeen;
        exp = model[4];
        @(negedge Clk);
        MemRead = 1'b1; Address = 32'h10;
        for (int c = 0; c < 4 * (LATENCY + 2) + 3; c++) begin
            @(negedge Clk);
            if (Ready === 1'b1) begin
                when.push_back(c);
                checks++; if (ReadData !== exp || Error !== 1'b0) begin errors++; $display("FAIL b2b_data: got %h/%b expected %h/0", ReadData, Error, exp); end
            end
        end
        MemRead = 1'b0;
        checks++; if (when.size() < 3) begin errors++; $display("FAIL b2b_count: got %0d pulses expected at least 3", when.size()); end
        if (when.size() > 0) begin
            checks++; if (when[0] != LATENCY) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", when[0], LATENCY); end
        end
        for (int i = 1; i < when.size(); i++) begin
            checks++; if (when[i] - when[i-1] != LATENCY + 2) begin errors++; $display("FAIL b2b_period: got %0d expected %0d", when[i] - when[i-1], LATENCY + 2); end
        end
        idleSeen = 0;
        for (int c = 0; c < 40 && idleSeen == 0; c++) begin
            @(negedge Clk);
            if (Busy === 1'b0 && Ready === 1'b0) idleSeen = 1;
        end
        checks++; if (idleSeen == 0) begin errors++; $display("FAIL b2b_drain: responder stayed busy, got %b expected 0", Busy); end
    endtask

    task automatic test_full_sweep;
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1, 0, 32'(i * 4), 32'h0, 0);
            checks++; if (obsData !== model[i] || obsErr !== 1'b0) begin errors++; $display("FAIL sweep_word%0d: got %h/%b expected %h/0", i, obsData, obsErr, model[i]); end
        end
    endtask

    initial begin
        foreach (model[i]) model[i] = 32'd0;
        test_reset();
        test_write_read();
        test_errors();
        test_wait_ignores_inputs();
        test_reset_in_wait();
        test_reset_with_request();
        test_random();
        test_back_to_back();
        test_full_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
